hazard_ctrl: RTL
================

# hazard_ctrl

Central hazard and sequencing controller for the five-stage MIPS pipeline. It watches the ID, EX and MEM stage register fields and drives the stall, flush and bubble controls of the IF/ID and ID/EX pipeline registers and the PC. It also owns the multi-cycle multiply/divide sequencer that blocks HI/LO consumers until a result is ready.

## Interface
Parameters:
- MULT_LAT, 4, multiply occupancy in cycles (≥1)
- DIV_LAT, 32, divide occupancy in cycles (≥1)
- CNT_W, 6, occupancy counter width; must hold max(MULT_LAT, DIV_LAT)-1
- REG_W, 5, register-address width

Ports (one clock; reset asynchronous, active-low):
- clk  in  1  pipeline clock; controller state updates on posedge
- reset_n  in  1  async active-low reset
- ifid_rs, ifid_rt  in  REG_W  source registers of the instruction in ID
- id_uses_rs, id_uses_rt  in  1  ID instruction actually reads rs / rt
- id_is_branch  in  1  ID instruction is a conditional branch resolved in ID
- id_branch_taken  in  1  ID branch comparator result
- id_jump  in  1  ID instruction is j/jal/jr/jalr
- id_reads_hilo  in  1  ID instruction is mfhi/mflo
- id_md_op  in  1  ID instruction is mult/multu/div/divu
- idex_dst  in  REG_W  EX-stage destination register
- idex_reg_write, idex_mem_read  in  1  EX-stage write-back / load flags
- exmem_dst  in  REG_W  MEM-stage destination register
- exmem_mem_read  in  1  MEM-stage load flag
- ex_md_start  in  1  mult/div enters EX this cycle
- ex_md_is_div  in  1  qualifies ex_md_start: 1 divide, 0 multiply
- cu_stall  out  1  hold PC and IF/ID
- cu_flush  out  1  clear IF/ID (squash wrong-path fetch)
- cu_bubble  out  1  clear ID/EX (insert NOP)
- md_busy  out  1  sequencer occupied
- md_done  out  1  final occupancy cycle; HI/LO written this cycle

## Operation
- dep(d) = d≠0 ∧ ((id_uses_rs ∧ d==ifid_rs) ∨ (id_uses_rt ∧ d==ifid_rt)).
- load_use = idex_mem_read ∧ dep(idex_dst).
- branch_dep = (id_is_branch ∨ id_jump) ∧ ((idex_reg_write ∧ dep(idex_dst)) ∨ (exmem_mem_read ∧ dep(exmem_dst))). Applies to jr/jalr, which read rs.
- hilo_wait = md_busy ∧ (id_reads_hilo ∨ id_md_op).
- stall = load_use ∨ branch_dep ∨ hilo_wait; cu_stall = cu_bubble = stall.
- cu_flush = (id_jump ∨ (id_is_branch ∧ id_branch_taken)) ∧ ¬stall; the redirect is ignored while its operands are stale.
- Sequencer states: IDLE, BUSY. IDLE→BUSY on ex_md_start, loading cnt = (ex_md_is_div ? DIV_LAT : MULT_LAT) − 1. BUSY: cnt decrements each cycle; at cnt==0, md_done=1 and the next state is IDLE. ex_md_start while BUSY cannot occur (blocked by hilo_wait); if asserted anyway it is ignored.
- md_busy = (state==BUSY); md_done = BUSY ∧ cnt==0.
- Register $0 never creates a dependency.

## Timing
- cu_stall, cu_flush and cu_bubble are combinational on current inputs and state; they are stable before the negedge at which the pipeline registers sample them.
- Load-use: exactly 1 stall cycle. Load followed immediately by a dependent branch: 2 stall cycles. ALU result feeding a branch: 1 stall cycle.
- Multiply issued in EX at cycle t: md_busy high for cycles t+1 … t+MULT_LAT, md_done in cycle t+MULT_LAT; a waiting mfhi leaves ID in cycle t+MULT_LAT+1.
- Reset (any time, including mid-BUSY): state IDLE, cnt 0, md_busy=0, md_done=0, perf counters 0; an in-flight operation is abandoned. Outputs are 0 whenever inputs are idle.

## Configuration
- HAZARD_PERF_CNT_EN defined: adds input perf_clr and 32-bit outputs perf_stall_cyc (cycles with stall), perf_flush_cnt (cycles with cu_flush) and perf_md_wait (cycles with hilo_wait). Counters wrap at 2^32; perf_clr synchronously zeroes all three and takes priority over increments.
- Not defined: these ports and counters are absent; hazard behaviour is identical.

## Structure
- pipeline_pkg: REG_W, the MD state enum {MD_IDLE, MD_BUSY} and the default MULT_LAT/DIV_LAT constants, shared with the ID/EX stages.
- Sub-module hazard_md_seq: the IDLE/BUSY FSM and its counter. The top level holds the dependency logic and the optional perf counters.

## Test plan
- lw $2 in EX, ID add reads $2 -> cu_stall=cu_bubble=1 for 1 cycle, then 0; cu_flush=0.
- lw $3 in EX, then beq $3,$0 in ID (taken) -> stall 2 cycles, cu_flush=1 in cycle 3 only.
- ex_md_start with ex_md_is_div=1, mflo held in ID -> md_busy for 32 cycles, md_done in the 32nd, stall released the cycle after.
- Multiply with reset_n pulsed low at BUSY cnt=2 -> md_busy=0 immediately, no md_done.
- Destination $0 in EX as a load, ID reads $0 -> no stall.
- With HAZARD_PERF_CNT_EN: 3 stall cycles, then perf_clr -> perf_stall_cyc reads 3, then 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: register width, multiply/divide sequencer states and default latencies
// shared by the ID/EX stages and the hazard controller.
package pipeline_pkg;
    localparam int REG_W    = 5;
    localparam int MULT_LAT = 4;
    localparam int DIV_LAT  = 32;
    typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;
endpackage

// File: rtl/hazard_md_seq.sv
// hazard_md_seq: IDLE/BUSY multiply/divide occupancy sequencer; busy for the full
// latency after a start, done on the final occupancy cycle.
module hazard_md_seq #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 32,
    parameter int CNT_W    = 6
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic is_div,
    output logic busy,
    output logic done
);
    import pipeline_pkg::*;

    md_state_t        state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // A start while BUSY is ignored; the ID-stage stall normally prevents it.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (state == MD_IDLE) begin
            if (start) begin
                state_nx = MD_BUSY;
                cnt_nx   = is_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MULT_LAT - 1);
            end
        end else if (cnt == '0) begin
            state_nx = MD_IDLE;
        end else begin
            cnt_nx = cnt - 1'b1;
        end
    end

    assign busy = (state == MD_BUSY);
    assign done = busy && (cnt == '0);
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / branch-operand / HI-LO hazard detection for the 5-stage pipeline.
// Optional HAZARD_PERF_CNT_EN adds stall, flush and md-wait cycle counters.
module hazard_ctrl #(
    parameter int MULT_LAT = pipeline_pkg::MULT_LAT,
    parameter int DIV_LAT  = pipeline_pkg::DIV_LAT,
    parameter int CNT_W    = 6,
    parameter int REG_W    = pipeline_pkg::REG_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_branch,
    input  logic             id_branch_taken,
    input  logic             id_jump,
    input  logic             id_reads_hilo,
    input  logic             id_md_op,
    input  logic [REG_W-1:0] idex_dst,
    input  logic             idex_reg_write,
    input  logic             idex_mem_read,
    input  logic [REG_W-1:0] exmem_dst,
    input  logic             exmem_mem_read,
    input  logic             ex_md_start,
    input  logic             ex_md_is_div,
    output logic             cu_stall,
    output logic             cu_flush,
    output logic             cu_bubble,
    output logic             md_busy,
    output logic             md_done
`ifdef HAZARD_PERF_CNT_EN
    ,
    input  logic             perf_clr,
    output logic [31:0]      perf_stall_cyc,
    output logic [31:0]      perf_flush_cnt,
    output logic [31:0]      perf_md_wait
`endif
);
    logic dep_ex, dep_mem, load_use, branch_dep, hilo_wait, stall;

    // Register $0 is hardwired, so it never carries a dependency.
    assign dep_ex  = (idex_dst != '0) &&
                     ((id_uses_rs && idex_dst == ifid_rs) || (id_uses_rt && idex_dst == ifid_rt));
    assign dep_mem = (exmem_dst != '0) &&
                     ((id_uses_rs && exmem_dst == ifid_rs) || (id_uses_rt && exmem_dst == ifid_rt));

    assign load_use   = idex_mem_read && dep_ex;
    assign branch_dep = (id_is_branch || id_jump) &&
                        ((idex_reg_write && dep_ex) || (exmem_mem_read && dep_mem));
    assign hilo_wait  = md_busy && (id_reads_hilo || id_md_op);
    assign stall      = load_use || branch_dep || hilo_wait;

    assign cu_stall  = stall;
    assign cu_bubble = stall;
    assign cu_flush  = (id_jump || (id_is_branch && id_branch_taken)) && !stall;

    hazard_md_seq #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) u_md_seq (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (ex_md_start),
        .is_div  (ex_md_is_div),
        .busy    (md_busy),
        .done    (md_done)
    );

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_stall_cyc <= '0;
            perf_flush_cnt <= '0;
            perf_md_wait   <= '0;
        end else if (perf_clr) begin
            perf_stall_cyc <= '0;
            perf_flush_cnt <= '0;
            perf_md_wait   <= '0;
        end else begin
            perf_stall_cyc <= perf_stall_cyc + 32'(stall);
            perf_flush_cnt <= perf_flush_cnt + 32'(cu_flush);
            perf_md_wait   <= perf_md_wait + 32'(hilo_wait);
        end
    end
`endif
endmodule
